// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter that owns the select lines of the shared 32-bit
// tri-state bus drivers. A registered one-hot grant enables exactly one
// driver at a time, and a mandatory one-cycle turnaround slot (no driver
// enabled) separates consecutive owners, including a requester that wins
// twice in a row.
//
// Optional feature (macro BUS_ARB_TIMEOUT_EN):
//   defined   - burst counter compiled in; an owner that has held the bus for
//               MAX_BURST cycles is preempted when any other source waits.
//   undefined - no counter; the owner keeps the bus until it drops req and
//               MAX_BURST is only range-checked.
//
// Parameters:
//   NUM_REQ    number of requesters / tri-state drivers
//   ID_W       width of grant_id, 2**ID_W >= NUM_REQ
//   MAX_BURST  longest continuous grant before forced rotation
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   req         per-source level-sensitive bus request
//   grant       registered one-hot grant, bit i drives select of buffer i
//   grant_id    registered index of the current owner, 0 when idle
//   bus_busy    high while a driver owns the bus (OR of grant)
//   turnaround  high during the dead cycle between owners
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               bus_busy,
  output logic               turnaround
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  // Reject configurations that cannot encode every owner or never rotate.
  if (NUM_REQ < 1 || (1 << ID_W) < NUM_REQ || MAX_BURST < 1) begin : g_param_check
    $error("bus_arbiter: illegal NUM_REQ/ID_W/MAX_BURST combination");
  end

  logic [1:0]         state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [ID_W-1:0]    grant_id_reg, grant_id_next;
  logic [ID_W-1:0]    last_reg, last_next;

  // ---------------------------------------------------------------------------
  // Winner selection: first asserted req at or after last+1, wrapping.
  // Implemented as "lowest set bit above last, else lowest set bit overall",
  // which is the same rotation without a variable modulo index.
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] pick_src;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_valid;
  logic [ID_W-1:0]    win_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign upper_mask[gi] = (ID_W'(gi) > last_reg);
  end

  assign pick_src  = (|(req & upper_mask)) ? (req & upper_mask) : req;
  assign win_valid = |req;

  always_comb begin
    win_idx = '0;
    // Descending scan so the lowest set bit is the one left standing.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        win_idx = ID_W'(i);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_win_onehot
    assign win_onehot[gi] = win_valid && (win_idx == ID_W'(gi));
  end

  // Owner status while in GRANT: the owner's bit is the registered grant.
  logic owner_req;
  logic others_pending;
  logic rotate;

  assign owner_req      = |(req & grant_reg);
  assign others_pending = |(req & ~grant_reg);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] count_reg, count_next;

  assign rotate = (count_reg == CNT_W'(MAX_BURST)) && others_pending;
`else
  assign rotate = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    last_next     = last_reg;
`ifdef BUS_ARB_TIMEOUT_EN
    count_next    = count_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_TURN: begin
        // TURN arbitrates with last already pointing at the previous owner,
        // so a preempted owner that keeps requesting is served last.
        if (win_valid) begin
          state_next    = ST_GRANT;
          grant_next    = win_onehot;
          grant_id_next = win_idx;
          last_next     = win_idx;
`ifdef BUS_ARB_TIMEOUT_EN
          count_next    = CNT_W'(1);
`endif
        end else begin
          state_next    = ST_IDLE;
          grant_next    = '0;
          grant_id_next = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || rotate) begin
          state_next    = ST_TURN;
          grant_next    = '0;
          grant_id_next = '0;
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
          if (count_reg != CNT_W'(MAX_BURST)) begin
            count_next = count_reg + CNT_W'(1);
          end
`endif
        end
      end
      default: begin
        state_next    = ST_IDLE;
        grant_next    = '0;
        grant_id_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      last_reg     <= ID_W'(NUM_REQ - 1);
`ifdef BUS_ARB_TIMEOUT_EN
      count_reg    <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      last_reg     <= last_next;
`ifdef BUS_ARB_TIMEOUT_EN
      count_reg    <= count_next;
`endif
    end
  end

  assign grant      = grant_reg;
  assign grant_id   = grant_id_reg;
  assign bus_busy   = (state_reg == ST_GRANT);
  assign turnaround = (state_reg == ST_TURN);

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed scenarios followed by randomized requests, all checked every cycle
// against a behavioural model that tracks the owner as an integer index, a
// turnaround flag and a rotation pointer. Builds with or without
// BUS_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int MB   = 8;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  localparam int STARVE_BOUND = (N - 1) * (MB + 1) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  grant;
  logic [ID_W-1:0] grant_id;
  logic          bus_busy;
  logic          turnaround;

  int n_assert = 0;
  int n_fail   = 0;

  bus_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .grant      (grant),
    .grant_id   (grant_id),
    .bus_busy   (bus_busy),
    .turnaround (turnaround)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_owner;   // -1 when nobody owns the bus
  bit m_gap;     // dead cycle between owners
  int m_rr;      // index of the most recent winner
  int m_held;    // cycles the current owner has held the bus

  logic [N-1:0] prev_grant;

  task automatic model_reset();
    m_owner = -1;
    m_gap   = 1'b0;
    m_rr    = N - 1;
    m_held  = 0;
    prev_grant = '0;
  endtask

  function automatic int model_winner(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_clock(input logic [N-1:0] r);
    bit others;
    int w;
    others = 1'b0;
    if (m_owner >= 0) begin
      for (int j = 0; j < N; j++) begin
        if (j != m_owner && r[j]) others = 1'b1;
      end
      if (!r[m_owner] || (TO && m_held >= MB && others)) begin
        m_owner = -1;
        m_gap   = 1'b1;
      end else if (m_held < MB) begin
        m_held++;
      end
    end else begin
      w = model_winner(r);
      m_gap = 1'b0;
      if (w >= 0) begin
        m_owner = w;
        m_rr    = w;
        m_held  = 1;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] exp_grant;
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("bus_busy", 32'(bus_busy), 32'(m_owner >= 0));
    chk("turnaround", 32'(turnaround), 32'(m_gap));
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
    // A change of owner must pass through an all-zero grant cycle.
    chk("owner_gap", 32'(prev_grant == '0 || grant == '0 || prev_grant == grant), 32'd1);
    prev_grant = grant;
  endtask

  task automatic step(input logic [N-1:0] r);
    req = r;
    model_clock(r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int cnt;
  int wait_cnt [N];
  logic [N-1:0] rnd_req;

  initial begin
    model_reset();
    #2;
    chk("async_reset_no_clock", 32'(grant), 32'd0);
    do_reset();
    chk("reset_grant_id", 32'(grant_id), 32'd0);

    // Single request held 3 cycles, then released.
    for (int k = 0; k < 3; k++) begin
      step(4'b0100);
      chk("single_grant", 32'(grant), 32'b0100);
      chk("single_id", 32'(grant_id), 32'd2);
    end
    step(4'b0000);
    chk("single_turn", 32'(turnaround), 32'd1);
    step(4'b0000);
    chk("single_idle", 32'({grant, turnaround}), 32'd0);

    // Round-robin fairness from reset: every owner drops after one cycle.
    do_reset();
    step(4'b1111); chk("rr_0", 32'(grant), 32'b0001);
    step(4'b1110); chk("rr_t0", 32'({bus_busy, turnaround}), 32'b01);
    step(4'b1111); chk("rr_1", 32'(grant), 32'b0010);
    step(4'b1101); chk("rr_t1", 32'({bus_busy, turnaround}), 32'b01);
    step(4'b1111); chk("rr_2", 32'(grant), 32'b0100);
    step(4'b1011); chk("rr_t2", 32'({bus_busy, turnaround}), 32'b01);
    step(4'b1111); chk("rr_3", 32'(grant), 32'b1000);
    step(4'b0111); chk("rr_t3", 32'({bus_busy, turnaround}), 32'b01);
    step(4'b1111); chk("rr_4", 32'(grant), 32'b0001);
    step(4'b0000);
    step(4'b0000);

    // Long burst by req[1] with req[3] raised on the third cycle.
    cnt = 0;
    step(4'b0010); if (grant === 4'b0010) cnt++;
    step(4'b0010); if (grant === 4'b0010) cnt++;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int k = 0; k < 7; k++) begin
      step(4'b1010);
      if (grant === 4'b0010) cnt++;
    end
    chk("burst_len", 32'(cnt), 32'(MB));
    chk("burst_turn", 32'(turnaround), 32'd1);
    step(4'b1010);
    chk("burst_next", 32'(grant), 32'b1000);
`else
    for (int k = 0; k < 50; k++) begin
      step(4'b1010);
      if (grant === 4'b0010) cnt++;
    end
    chk("burst_len", 32'(cnt), 32'd52);
    step(4'b1000);
    chk("burst_turn", 32'(turnaround), 32'd1);
    step(4'b1000);
    chk("burst_next", 32'(grant), 32'b1000);
`endif

    // Asynchronous reset between clock edges while 0100 owns the bus.
    do_reset();
    step(4'b0100);
    chk("pre_async_grant", 32'(grant), 32'b0100);
    #2;
    reset = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_busy", 32'(bus_busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    step(4'b1111);
    chk("post_async_first", 32'(grant), 32'b0001);

    // Randomized requests with sticky bits so owners hold for a while.
    do_reset();
    rnd_req = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) rnd_req[i] = ~rnd_req[i];
      end
      step(rnd_req);
      for (int i = 0; i < N; i++) begin
        if (req[i] && !grant[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
`ifdef BUS_ARB_TIMEOUT_EN
        chk("starvation", 32'(wait_cnt[i] <= STARVE_BOUND), 32'd1);
`endif
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
